// File: rtl/o2a_pkg.sv
// Shared definitions for the O-buffer to A-buffer transfer engine:
// FSM state codes, activation range helpers and the start-time dimension check.
package o2a_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRead   = 3'd1;
  localparam logic [2:0] StDrain  = 3'd2;
  localparam logic [2:0] StWriteT = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  // Largest value of a signed activation of the given width (ACT_MAX).
  function automatic int act_max(input int unsigned width);
    return (1 << (width - 1)) - 1;
  endfunction

  // Smallest value of a signed activation of the given width (ACT_MIN).
  function automatic int act_min(input int unsigned width);
    return -(1 << (width - 1));
  endfunction

  // Row mode writes column j of a row into bank j, so columns are also bounded by the bank count.
  function automatic logic dims_legal(input int unsigned rows, input int unsigned cols,
                                      input int unsigned max_rows, input int unsigned max_cols,
                                      input logic xpose);
    return (rows >= 1) && (rows <= max_rows) && (cols >= 1) && (cols <= max_cols) &&
           (xpose || (cols <= max_rows));
  endfunction

endpackage

// File: rtl/o2a_transfer_engine_requant_lane.sv
// One requantisation lane: rounding arithmetic right shift, optional ReLU, signed saturation.
// Purely combinational; the engine registers the result.
module requant_lane
  import o2a_pkg::*;
#(
  parameter int unsigned ACT_WIDTH   = 8,
  parameter int unsigned OUT_WIDTH   = 32,
  parameter int unsigned SHIFT_WIDTH = 5
) (
  input  logic [OUT_WIDTH-1:0]   x_i,
  input  logic [SHIFT_WIDTH-1:0] shift_i,
  input  logic                   relu_en_i,
  output logic [ACT_WIDTH-1:0]   y_o
);

  // One extra bit so the rounding add can never overflow.
  localparam int unsigned XW = OUT_WIDTH + 1;
  localparam logic signed [XW-1:0] SatHi = XW'(act_max(ACT_WIDTH));
  localparam logic signed [XW-1:0] SatLo = XW'(act_min(ACT_WIDTH));

  logic signed [XW-1:0] x_ext, rnd, sum, y;

  // Round half up, shift, clamp negatives if requested, then saturate.
  always_comb begin
    x_ext = XW'($signed(x_i));
    rnd   = '0;
    if (shift_i != '0) begin
      rnd = XW'(1) << (shift_i - SHIFT_WIDTH'(1));
    end
    sum = x_ext + rnd;
    if (shift_i == '0) begin
      y = x_ext;
    end else if (int'(shift_i) >= int'(OUT_WIDTH)) begin
      y = x_ext[XW-1] ? '1 : '0;
    end else begin
      y = sum >>> shift_i;
    end
    if (relu_en_i && y[XW-1]) begin
      y = '0;
    end
    if (y > SatHi) begin
      y_o = SatHi[ACT_WIDTH-1:0];
    end else if (y < SatLo) begin
      y_o = SatLo[ACT_WIDTH-1:0];
    end else begin
      y_o = y[ACT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/o2a_transfer_engine.sv
// O-buffer to A-buffer transfer engine: reads a tile of accumulator rows, requantises each lane
// and writes it to the A-buffer banks row-for-row or transposed.
// Build option: define O2A_ZERO_PAD_EN to enable all banks on every write beat (zero padding).
module o2a_transfer_engine
  import o2a_pkg::*;
#(
  parameter int unsigned ARRAY_N     = 16,
  parameter int unsigned ARRAY_M     = 16,
  parameter int unsigned ACT_WIDTH   = 8,
  parameter int unsigned OUT_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned SHIFT_WIDTH = 5,
  localparam int unsigned RW = $clog2(ARRAY_N) + 1,
  localparam int unsigned CW = $clog2(ARRAY_M) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [RW-1:0]                num_rows,
  input  logic [CW-1:0]                num_cols,
  input  logic [ADDR_WIDTH-1:0]        o_base_addr,
  input  logic [ADDR_WIDTH-1:0]        a_base_addr,
  input  logic [SHIFT_WIDTH-1:0]       shift,
  input  logic                         relu_en,
  input  logic                         transpose,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic                         o_rd_en,
  output logic [ADDR_WIDTH-1:0]        o_rd_addr,
  input  logic [OUT_WIDTH*ARRAY_M-1:0] o_rd_data,
  output logic [ARRAY_N-1:0]           a_wr_en,
  output logic [ADDR_WIDTH-1:0]        a_wr_addr,
  output logic [ACT_WIDTH*ARRAY_N-1:0] a_wr_data
);

  localparam int unsigned KW    = (RW > CW) ? RW : CW;
  localparam int unsigned LANES = (ARRAY_N < ARRAY_M) ? ARRAY_N : ARRAY_M;

  logic [2:0]             state_q, state_d;
  logic [KW-1:0]          cnt_q, cnt_d;
  logic                   error_q, error_d, accept;
  logic [RW-1:0]          rows_q;
  logic [CW-1:0]          cols_q;
  logic [ADDR_WIDTH-1:0]  o_base_q, a_base_q;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic                   relu_q, xpose_q;

  logic [RD_LAT-1:0]      pipe_vld_q;
  logic [RW-1:0]          pipe_row_q [RD_LAT];
  logic                   ret_vld_q;
  logic [RW-1:0]          ret_row_q;
  logic [ACT_WIDTH-1:0]   ret_data_q [ARRAY_M];
  logic [ACT_WIDTH-1:0]   rq         [ARRAY_M];
  logic [ACT_WIDTH-1:0]   tile_q     [ARRAY_N][ARRAY_M];

  logic                   last_read, last_col, last_ret, beat;
  logic [ARRAY_N-1:0]     active, wr_mask;

  for (genvar j = 0; j < ARRAY_M; j++) begin : g_lane
    requant_lane #(
      .ACT_WIDTH  (ACT_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_requant (
      .x_i      (o_rd_data[j*OUT_WIDTH +: OUT_WIDTH]),
      .shift_i  (shift_q),
      .relu_en_i(relu_q),
      .y_o      (rq[j])
    );
  end

  assign last_read = (cnt_q == KW'(rows_q) - KW'(1));
  assign last_col  = (cnt_q == KW'(cols_q) - KW'(1));
  assign last_ret  = ret_vld_q && (ret_row_q == rows_q - RW'(1));

  // Next-state logic: start acceptance, read sequencing, drain and transposed write-out.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    error_d = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (dims_legal(32'(num_rows), 32'(num_cols), ARRAY_N, ARRAY_M, transpose)) begin
            accept  = 1'b1;
            state_d = StRead;
            cnt_d   = '0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StRead: begin
        if (last_read) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      StDrain: begin
        if (last_ret) begin
          state_d = xpose_q ? StWriteT : StDone;
        end
      end
      StWriteT: begin
        if (last_col) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM, configuration latch, read-latency tracking and the registered requant stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      error_q    <= 1'b0;
      rows_q     <= '0;
      cols_q     <= '0;
      o_base_q   <= '0;
      a_base_q   <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      xpose_q    <= 1'b0;
      pipe_vld_q <= '0;
      pipe_row_q <= '{default: '0};
      ret_vld_q  <= 1'b0;
      ret_row_q  <= '0;
      ret_data_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
      if (accept) begin
        rows_q   <= num_rows;
        cols_q   <= num_cols;
        o_base_q <= o_base_addr;
        a_base_q <= a_base_addr;
        shift_q  <= shift;
        relu_q   <= relu_en;
        xpose_q  <= transpose;
      end
      pipe_vld_q[0] <= o_rd_en;
      pipe_row_q[0] <= RW'(cnt_q);
      for (int k = 1; k < int'(RD_LAT); k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_row_q[k] <= pipe_row_q[k-1];
      end
      ret_vld_q  <= pipe_vld_q[RD_LAT-1];
      ret_row_q  <= pipe_row_q[RD_LAT-1];
      ret_data_q <= rq;
    end
  end

  // Transpose mode captures each returning row in the tile buffer; contents need no reset.
  always_ff @(posedge clk) begin
    if (reset && xpose_q && pipe_vld_q[RD_LAT-1]) begin
      for (int r = 0; r < int'(ARRAY_N); r++) begin
        if (pipe_row_q[RD_LAT-1] == RW'(r)) begin
          tile_q[r] <= rq;
        end
      end
    end
  end

  assign busy      = (state_q == StRead) || (state_q == StDrain) || (state_q == StWriteT);
  assign done      = (state_q == StDone);
  assign error     = error_q;
  assign o_rd_en   = (state_q == StRead);
  assign o_rd_addr = o_rd_en ? (o_base_q + ADDR_WIDTH'(cnt_q)) : '0;

  // Write beat: row mode forwards the requant register, transpose mode reads a tile column.
  always_comb begin
    beat      = 1'b0;
    active    = '0;
    a_wr_addr = '0;
    a_wr_data = '0;
    if (ret_vld_q && !xpose_q) begin
      beat      = 1'b1;
      a_wr_addr = a_base_q + ADDR_WIDTH'(ret_row_q);
      for (int j = 0; j < int'(LANES); j++) begin
        if (j < int'(cols_q)) begin
          active[j]                             = 1'b1;
          a_wr_data[j*ACT_WIDTH +: ACT_WIDTH] = ret_data_q[j];
        end
      end
    end else if (state_q == StWriteT) begin
      beat      = 1'b1;
      a_wr_addr = a_base_q + ADDR_WIDTH'(cnt_q);
      for (int r = 0; r < int'(ARRAY_N); r++) begin
        if (r < int'(rows_q)) begin
          active[r] = 1'b1;
          for (int c = 0; c < int'(ARRAY_M); c++) begin
            if (cnt_q == KW'(c)) begin
              a_wr_data[r*ACT_WIDTH +: ACT_WIDTH] = tile_q[r][c];
            end
          end
        end
      end
    end
  end

`ifdef O2A_ZERO_PAD_EN
  // Inactive lanes already carry 0, so enabling every bank zero-pads the tile.
  assign wr_mask = {ARRAY_N{1'b1}};
`else
  assign wr_mask = active;
`endif

  assign a_wr_en = beat ? wr_mask : '0;

endmodule

// File: tb/tb_o2a_transfer_engine.sv
// Self-checking bench for o2a_transfer_engine: a cycle-indexed expectation model plus directed
// literal checks. Honours O2A_ZERO_PAD_EN when computing expected write enables.
module tb_o2a_transfer_engine;

  localparam int N    = 16;
  localparam int M    = 16;
  localparam int AW   = 8;
  localparam int OW   = 32;
  localparam int RL   = 1;
  localparam int MAXC = 1024;

  logic             clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [4:0]       num_rows = '0, num_cols = '0, shift = '0;
  logic [9:0]       o_base_addr = '0, a_base_addr = '0;
  logic             relu_en = 1'b0, transpose = 1'b0;
  logic             busy, done, error, o_rd_en;
  logic [9:0]       o_rd_addr, a_wr_addr;
  logic [OW*M-1:0]  o_rd_data = '0;
  logic [N-1:0]     a_wr_en;
  logic [AW*N-1:0]  a_wr_data;

  o2a_transfer_engine dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows), .num_cols(num_cols),
    .o_base_addr(o_base_addr), .a_base_addr(a_base_addr), .shift(shift), .relu_en(relu_en),
    .transpose(transpose), .busy(busy), .done(done), .error(error), .o_rd_en(o_rd_en),
    .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr),
    .a_wr_data(a_wr_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0, free_at = 0;
  logic [OW*M-1:0] obuf [1024];

  // Expected outputs per cycle; zero means "idle" for every signal.
  bit              e_rd   [MAXC];
  bit [9:0]        e_rda  [MAXC];
  bit              e_busy [MAXC];
  bit              e_done [MAXC];
  bit              e_err  [MAXC];
  bit [N-1:0]      e_wen  [MAXC];
  bit [9:0]        e_wa   [MAXC];
  bit [AW*N-1:0]   e_wd   [MAXC];

  // Observed activity logs for directed checks.
  int              rd_log[$];
  int              wa_log[$];
  logic [127:0]    wd_log[$];
  logic [N-1:0]    we_log[$];
  int              done_cnt = 0, err_cnt = 0, busy_seen = 0, last_wr_cyc = 0, done_cyc = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  // Requantisation straight from its arithmetic definition, in 64-bit integers.
  function automatic logic [7:0] rq(input longint x, input int s, input bit relu);
    longint y;
    if (s == 0) y = x;
    else if (s >= OW) y = (x < 0) ? -1 : 0;
    else y = (x + (longint'(1) << (s - 1))) >>> s;
    if (relu && y < 0) y = 0;
    if (y > 127) y = 127;
    if (y < -128) y = -128;
    return 8'(y);
  endfunction

  function automatic bit [N-1:0] en_mask(input int n);
    bit [N-1:0] m = '0;
`ifdef O2A_ZERO_PAD_EN
    m = '1;
`else
    for (int i = 0; i < n; i++) m[i] = 1'b1;
`endif
    return m;
  endfunction

  function automatic longint lane(input int addr, input int j);
    logic [OW*M-1:0] row = obuf[addr % 1024];
    return longint'($signed(row[j*OW +: OW]));
  endfunction

  // Fill the expectation timeline for a start request seen during cycle s.
  task automatic model_start(input int s);
    int R = num_rows, C = num_cols, ob = o_base_addr, ab = a_base_addr, sh = shift;
    int last, w0, dc, t;
    bit legal;
    if (s < free_at) return;
    legal = (R >= 1) && (R <= N) && (C >= 1) && (C <= M) && (transpose || C <= N);
    if (!legal) begin
      e_err[s+1] = 1'b1;
      return;
    end
    for (int r = 0; r < R; r++) begin
      e_rd[s+1+r]  = 1'b1;
      e_rda[s+1+r] = 10'(ob + r);
    end
    last = s + R;
    if (!transpose) begin
      for (int r = 0; r < R; r++) begin
        t = s + 1 + r + RL + 1;
        e_wen[t] = en_mask(C);
        e_wa[t]  = 10'(ab + r);
        e_wd[t]  = '0;
        for (int j = 0; j < C; j++) e_wd[t][j*AW +: AW] = rq(lane(ob + r, j), sh, relu_en);
      end
      dc = last + RL + 2;
    end else begin
      w0 = last + RL + 2;
      for (int c = 0; c < C; c++) begin
        e_wen[w0+c] = en_mask(R);
        e_wa[w0+c]  = 10'(ab + c);
        e_wd[w0+c]  = '0;
        for (int r = 0; r < R; r++) e_wd[w0+c][r*AW +: AW] = rq(lane(ob + r, c), sh, relu_en);
      end
      dc = w0 + C;
    end
    for (int k = s + 1; k < dc; k++) e_busy[k] = 1'b1;
    e_done[dc] = 1'b1;
    free_at    = dc + 1;
  endtask

  // Reset sampled at the end of cycle k abandons everything scheduled after it.
  task automatic model_reset(input int k);
    for (int c = k + 1; c < MAXC; c++) begin
      e_rd[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_err[c] = 0; e_wen[c] = '0;
    end
    free_at = k + 1;
  endtask

  task automatic clear_logs();
    rd_log.delete(); wa_log.delete(); wd_log.delete(); we_log.delete();
    done_cnt = 0; err_cnt = 0; busy_seen = 0;
  endtask

  task automatic launch(input int r, input int c, input int ob, input int ab, input int sh,
                        input bit relu, input bit tr);
    @(posedge clk); #1;
    num_rows = 5'(r); num_cols = 5'(c); o_base_addr = 10'(ob); a_base_addr = 10'(ab);
    shift = 5'(sh); relu_en = relu; transpose = tr; start = 1'b1;
    model_start(cyc);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic set_lane(input int addr, input int j, input int v);
    obuf[addr][j*OW +: OW] = 32'(v);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // O-buffer model with a one-cycle read latency.
  initial begin
    bit       pend_en;
    bit [9:0] pend_addr;
    forever begin
      @(negedge clk);
      pend_en   = o_rd_en;
      pend_addr = o_rd_addr;
      @(posedge clk); #1;
      o_rd_data = pend_en ? obuf[pend_addr] : '0;
    end
  end

  // Per-cycle comparison against the model, plus activity logging.
  initial forever begin
    @(negedge clk);
    if (cyc >= 1 && cyc < MAXC) begin
      chk("rd_en", o_rd_en, e_rd[cyc]);
      if (e_rd[cyc]) chk("rd_addr", o_rd_addr, e_rda[cyc]);
      chk("busy", busy, e_busy[cyc]);
      chk("done", done, e_done[cyc]);
      chk("error", error, e_err[cyc]);
      chk("wr_en", a_wr_en, e_wen[cyc]);
      if (e_wen[cyc] != '0) begin
        chk("wr_addr", a_wr_addr, e_wa[cyc]);
        chk("wr_data", a_wr_data, e_wd[cyc]);
      end
    end
    if (o_rd_en) rd_log.push_back(int'(o_rd_addr));
    if (a_wr_en != '0) begin
      wa_log.push_back(int'(a_wr_addr));
      wd_log.push_back(a_wr_data);
      we_log.push_back(a_wr_en);
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (error) err_cnt++;
    if (busy) busy_seen++;
  end

  int           exp_rd [4] = '{1022, 1023, 0, 1};
  int           exp_wa [4] = '{1023, 0, 1, 2};
  logic [127:0] v;

  initial begin
    for (int a = 0; a < 1024; a++) obuf[a] = '0;

    // Model spot checks with hand-computed values.
    chk("model_rq_24", rq(24, 4, 0), 8'h02);
    chk("model_rq_m24", rq(-24, 4, 0), 8'hFF);
    chk("model_rq_5000", rq(5000, 4, 0), 8'h7F);
    chk("model_rq_m5000", rq(-5000, 4, 0), 8'h80);
    chk("model_rq_relu", rq(-24, 4, 1), 8'h00);

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_rd_addr", o_rd_addr, 0);
    chk("rst_wr_en", a_wr_en, 0);
    chk("rst_wr_addr", a_wr_addr, 0);
    chk("rst_wr_data", a_wr_data, 0);

    // Row mode: 4 rows, every lane of row r equals r.
    for (int r = 0; r < 4; r++) for (int j = 0; j < M; j++) set_lane(100 + r, j, r);
    clear_logs();
    launch(4, 16, 100, 200, 0, 0, 0);
    repeat (15) @(posedge clk);
    chk("row_beats", wa_log.size(), 4);
    for (int r = 0; r < 4 && r < wa_log.size(); r++) begin
      for (int j = 0; j < N; j++) v[j*AW +: AW] = 8'(r);
      chk("row_addr", wa_log[r], 200 + r);
      chk("row_data", wd_log[r], v);
      chk("row_en", we_log[r], 16'hFFFF);
    end
    chk("row_done_cnt", done_cnt, 1);
    chk("row_done_gap", done_cyc - last_wr_cyc, 1);

    // Requantisation with shift 4, without and with ReLU.
    set_lane(300, 0, 24); set_lane(300, 1, -24); set_lane(300, 2, 5000); set_lane(300, 3, -5000);
    clear_logs();
    launch(1, 16, 300, 0, 4, 0, 0);
    repeat (10) @(posedge clk);
    chk("rq_beats", wd_log.size(), 1);
    if (wd_log.size() > 0) chk("rq_lanes", wd_log[0][31:0], 32'h807FFF02);
    clear_logs();
    launch(1, 16, 300, 0, 4, 1, 0);
    repeat (10) @(posedge clk);
    if (wd_log.size() > 0) chk("rq_relu_lanes", wd_log[0][31:0], 32'h007F0002);
    else chk("rq_relu_beats", wd_log.size(), 1);

    // Transpose: element(r,c) = 10r + c, 3 rows by 2 columns.
    for (int r = 0; r < 3; r++) for (int c = 0; c < M; c++) set_lane(400 + r, c, 10 * r + c);
    clear_logs();
    launch(3, 2, 400, 50, 0, 0, 1);
    repeat (15) @(posedge clk);
    chk("tr_beats", wa_log.size(), 2);
    if (wa_log.size() == 2) begin
      chk("tr_addr0", wa_log[0], 50);
      chk("tr_addr1", wa_log[1], 51);
      chk("tr_data0", wd_log[0], 128'h140A00);
      chk("tr_data1", wd_log[1], 128'h150B01);
`ifdef O2A_ZERO_PAD_EN
      chk("tr_en", we_log[0], 16'hFFFF);
`else
      chk("tr_en", we_log[0], 16'h0007);
`endif
    end
    chk("tr_done_cnt", done_cnt, 1);

    // Illegal dimensions: zero rows, then too many columns for row mode.
    clear_logs();
    launch(0, 4, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    launch(4, 17, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    chk("ill_err_cnt", err_cnt, 2);
    chk("ill_busy", busy_seen, 0);
    chk("ill_reads", rd_log.size(), 0);
    chk("ill_writes", wa_log.size(), 0);

    // Address wrap with a start while busy that must be ignored.
    clear_logs();
    launch(4, 8, 1022, 1023, 0, 0, 0);
    launch(2, 2, 5, 5, 0, 0, 1);
    repeat (15) @(posedge clk);
    chk("wrap_reads", rd_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++) chk("wrap_rd_addr", rd_log[i], exp_rd[i]);
    chk("wrap_writes", wa_log.size(), 4);
    for (int i = 0; i < 4 && i < wa_log.size(); i++) chk("wrap_wr_addr", wa_log[i], exp_wa[i]);
    chk("wrap_done_cnt", done_cnt, 1);

    // Reset in the middle of READ, then a fresh transfer.
    clear_logs();
    launch(8, 4, 600, 10, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset(cyc);
    @(posedge clk); #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_en", o_rd_en, 0);
    chk("mid_rst_rd_addr", o_rd_addr, 0);
    chk("mid_rst_wr_en", a_wr_en, 0);
    chk("mid_rst_wr_data", a_wr_data, 0);
    reset = 1'b1;
    repeat (15) @(posedge clk);
    chk("mid_rst_no_done", done_cnt, 0);
    clear_logs();
    launch(2, 4, 100, 20, 0, 0, 0);
    repeat (12) @(posedge clk);
    chk("post_rst_done", done_cnt, 1);
    chk("post_rst_writes", wa_log.size(), 2);
`ifdef O2A_ZERO_PAD_EN
    if (we_log.size() > 0) chk("post_rst_en", we_log[0], 16'hFFFF);
`else
    if (we_log.size() > 0) chk("post_rst_en", we_log[0], 16'h000F);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/o2a_transfer_engine.md
Name: o2a_transfer_engine

Overview:
- Parametrised successor of the fixed 16x16 O-buffer to A-buffer intra-network path.
- Reads a result tile of OUT_WIDTH-wide accumulator rows from the O-buffer and requantises each lane to ACT_WIDTH. Requantisation is a rounding arithmetic shift, optional ReLU, then signed saturation.
- Writes the requantised tile into the A-buffer banks, either row-for-row or transposed, so the next layer can run without an external round-trip.
- Sits between O_buffer and A_buffer. It is driven by the system FSM through a start/busy/done handshake.

Parameters:
- ARRAY_N, 16: number of A-buffer banks; maximum tile rows.
- ARRAY_M, 16: number of O-buffer lanes; maximum tile columns.
- ACT_WIDTH, 8: signed output activation width.
- OUT_WIDTH, 32: signed accumulator lane width.
- ADDR_WIDTH, 10: buffer address width.
- RD_LAT, 1: O-buffer read latency in cycles, from o_rd_en to o_rd_data valid; must be 1 or more.
- SHIFT_WIDTH, 5: width of the requantisation shift amount.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- num_rows  in  $clog2(ARRAY_N)+1  tile rows; legal range 1..ARRAY_N.
- num_cols  in  $clog2(ARRAY_M)+1  tile columns; legal range 1..ARRAY_M.
- o_base_addr  in  ADDR_WIDTH  first O-buffer row address.
- a_base_addr  in  ADDR_WIDTH  first A-buffer address.
- shift  in  SHIFT_WIDTH  right-shift amount for requantisation.
- relu_en  in  1  clamp negative values to 0.
- transpose  in  1  0 = row mode, 1 = transpose mode.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at transfer completion.
- error  out  1  one-cycle pulse when start carries illegal dimensions.
- o_rd_en  out  1  O-buffer read strobe.
- o_rd_addr  out  ADDR_WIDTH  O-buffer read address.
- o_rd_data  in  OUT_WIDTH*ARRAY_M  O-buffer row; lane j occupies bits [j*OUT_WIDTH +: OUT_WIDTH].
- a_wr_en  out  ARRAY_N  per-bank A-buffer write enables.
- a_wr_addr  out  ADDR_WIDTH  A-buffer write address.
- a_wr_data  out  ACT_WIDTH*ARRAY_N  A-buffer data; lane k goes to bank k.

Behaviour:
- Reset (reset==0 at a clock edge):
  - FSM goes to IDLE, including mid-transfer; the in-flight transfer is abandoned with no done pulse.
  - All outputs are 0, and the tile buffer contents are don't-care.
- FSM states: IDLE, READ, DRAIN, WRITE_T, DONE.
- IDLE:
  - start with legal dimensions latches all configuration inputs and goes to READ.
  - start with illegal dimensions (num_rows or num_cols equal to 0 or above its maximum) pulses error for one cycle and stays in IDLE.
  - start while not in IDLE is ignored.
- READ:
  - For r = 0..num_rows-1, one per cycle: o_rd_en=1, o_rd_addr = o_base_addr + r, wrapping modulo 2^ADDR_WIDTH.
  - After the last read, go to DRAIN.
- Return path: the row for read r is valid RD_LAT cycles after its read. It is requantised and registered in one stage, so its result is ready RD_LAT+1 cycles after the read.
- Requantisation, per lane x (signed OUT_WIDTH):
  - If shift > 0: y = (x + 2^(shift-1)) >>> shift, with the add computed at OUT_WIDTH+1 bits (round half up, no overflow). If shift == 0: y = x.
  - A shift of OUT_WIDTH or more yields the sign fill: 0 or -1.
  - If relu_en and y < 0, y = 0.
  - y is then saturated to [-2^(ACT_WIDTH-1), 2^(ACT_WIDTH-1)-1].
- Row mode (transpose=0):
  - Row r is written RD_LAT+1 cycles after its read to a_wr_addr = a_base_addr + r.
  - Lane j of the row drives a_wr_data lane j.
  - a_wr_en[j] = 1 for j < num_cols, else 0.
  - num_cols must be at most ARRAY_N; otherwise the start raises error.
  - DRAIN runs until the last write has issued, then goes to DONE.
- Transpose mode (transpose=1):
  - Returned rows are stored in an ARRAY_N x ARRAY_M x ACT_WIDTH tile buffer.
  - DRAIN waits for the last row to arrive, then goes to WRITE_T.
  - WRITE_T emits, for c = 0..num_cols-1, one per cycle: a_wr_addr = a_base_addr + c; a_wr_data lane r = tile[r][c]; a_wr_en[r] = 1 for r < num_rows.
  - After the last column, go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Outside active beats, o_rd_en and a_wr_en are 0.
- Address wrap-around is silent, with no error.

Optional Feature:
- O2A_ZERO_PAD_EN defined: every beat asserts all ARRAY_N a_wr_en bits, and lanes beyond the active count are written as 0. This zero-pads partial tiles for the next layer.
- Undefined: enables are masked exactly as described in Behaviour, and unused lanes are driven 0 but not written.

Decomposition:
- Package o2a_pkg holds the FSM state enum, the ACT_MAX/ACT_MIN constants derived from ACT_WIDTH, and the legal-dimension check function.
- Sub-module requant_lane: one lane of round, shift, ReLU and saturation, combinational. The engine instantiates it ARRAY_M times ahead of the output register.

Test Plan:
- Row mode, num_rows=4, num_cols=16, shift=0, RD_LAT=1, row r lanes = r → writes at a_base..a_base+3 with all lanes = r, a_wr_en=0xFFFF; done pulses once, one cycle after the last write.
- Requantisation, shift=4: x=24 → 2 (rounds up); x=-24 → -1; x=5000 → 127; x=-5000 → -128. With relu_en=1, -24 → 0.
- Transpose, num_rows=3, num_cols=2, element(r,c) = 10r+c → 2 write beats: addr a_base has lanes {0,10,20}, addr a_base+1 has lanes {1,11,21}, a_wr_en=0x0007.
- Illegal start, num_rows=0 → error pulses for 1 cycle, busy stays 0, no reads or writes.
- Wrap and re-trigger: o_base_addr=1022, num_rows=4 → reads 1022, 1023, 0, 1. A start during busy is ignored.
- Reset asserted mid-READ → all outputs 0 next cycle, no done pulse. A fresh start then completes normally.
